// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller, ALU and datapath.
//   state_t  : controller state encoding (also driven on the debug state port)
//   OP_*     : instruction opcode field [31:26]
//   FN_*     : R-type funct field [5:0]
//   ALU_*    : ALU operation select
//   SRCB_*   : ALU B-operand mux select
//   PCSRC_*  : PC source mux select
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_ADDI_EXEC = 4'd9,
      S_IMM_WB    = 4'd10,
      S_LUI_EXEC  = 4'd11,
      S_JUMP      = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_LUI = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct to ALU operation decode (purely combinational).
//   i_funct   : funct field of the instruction
//   o_alu_op  : ALU operation; ADD for an unrecognised funct
//   o_unknown : high when i_funct is not a supported operation
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_op,
   output logic       o_unknown
);

   always_comb begin
      o_alu_op  = ALU_ADD;
      o_unknown = 1'b0;
      case (i_funct)
         FN_ADD:  o_alu_op = ALU_ADD;
         FN_SUB:  o_alu_op = ALU_SUB;
         FN_AND:  o_alu_op = ALU_AND;
         FN_OR:   o_alu_op = ALU_OR;
         FN_SLT:  o_alu_op = ALU_SLT;
         default: o_unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit (Moore FSM; pc_en in BRANCH follows zero).
//   clk, reset           : single clock, synchronous active-high reset
//   opcode, funct, zero  : instruction fields (sampled in DECODE / R_EXEC), ALU zero flag
//   pc_en .. alu_src_a   : datapath enables and mux selects
//   alu_src_b, pc_src    : 2-bit mux selects
//   alu_op               : ALU operation
//   state, illegal       : debug state, one-cycle undecodable-instruction pulse
//
// state       | meaning
// FETCH       | read instruction, PC <= PC + 4
// DECODE      | register read, branch target into ALUOut, dispatch on opcode
// MEM_ADDR    | lw/sw effective address
// MEM_READ    | data memory read
// MEM_WB      | load result to register file
// MEM_WRITE   | data memory write
// R_EXEC      | R-type ALU operation
// R_WB        | R-type result to rd
// BRANCH      | beq compare, PC <= ALUOut when zero
// ADDI_EXEC   | rs + sign-extended immediate
// IMM_WB      | immediate result to rt
// LUI_EXEC    | upper-immediate load through ALU
// JUMP        | PC <= jump target
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int STRICT_DECODE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       illegal
);

   state_t     r_state;
   state_t     w_next;
   logic       r_is_sw;
   logic       r_funct_bad;
   logic [2:0] w_rtype_op;
   logic       w_funct_unknown;
   logic       w_strict;

   assign w_strict = (STRICT_DECODE != 0);
   assign state    = r_state;

   alu_decoder u_alu_decoder (
      .i_funct   (funct),
      .o_alu_op  (w_rtype_op),
      .o_unknown (w_funct_unknown)
   );

   // lw/sw choice and funct validity are captured when the fields are
   // sampled, so later changes on opcode/funct cannot steer the sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_is_sw     <= 1'b0;
         r_funct_bad <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_is_sw <= (opcode == OP_SW);
         end
         if (r_state == S_R_EXEC) begin
            r_funct_bad <= w_funct_unknown;
         end
      end
   end

   always_comb begin
      w_next     = S_FETCH;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_src     = PCSRC_ALU;
      alu_op     = 3'b000;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            pc_src    = PCSRC_ALU;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            alu_op    = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_RTYPE:     w_next = S_R_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDI_EXEC;
               OP_LUI:       w_next = S_LUI_EXEC;
               OP_J:         w_next = S_JUMP;
               default: begin
                  w_next  = S_FETCH;
                  illegal = w_strict;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            w_next    = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            i_or_d = 1'b1;
            w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_REG;
            alu_op    = w_rtype_op;
            illegal   = w_strict & w_funct_unknown;
            w_next    = S_R_WB;
         end
         S_R_WB: begin
            reg_dst   = 1'b1;
            reg_write = ~r_funct_bad;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_REG;
            alu_op    = ALU_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_en     = zero;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            w_next    = S_IMM_WB;
         end
         S_LUI_EXEC: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_LUI;
            w_next    = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_en  = 1'b1;
            pc_src = PCSRC_JUMP;
         end
         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;

   logic       pc_en1, ir_write1, i_or_d1, mem_write1, reg_write1, reg_dst1, mem_to_reg1, alu_src_a1, illegal1;
   logic [1:0] alu_src_b1, pc_src1;
   logic [2:0] alu_op1;
   logic [3:0] state1;
   logic       pc_en0, ir_write0, i_or_d0, mem_write0, reg_write0, reg_dst0, mem_to_reg0, alu_src_a0, illegal0;
   logic [1:0] alu_src_b0, pc_src0;
   logic [2:0] alu_op0;
   logic [3:0] state0;

   int checks = 0;
   int errors = 0;
   state_t q_path[$];

   multicycle_control #(.STRICT_DECODE(1)) dut_strict (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en1), .ir_write(ir_write1), .i_or_d(i_or_d1), .mem_write(mem_write1),
      .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .alu_src_a(alu_src_a1),
      .alu_src_b(alu_src_b1), .pc_src(pc_src1), .alu_op(alu_op1), .state(state1), .illegal(illegal1)
   );

   multicycle_control #(.STRICT_DECODE(0)) dut_loose (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en0), .ir_write(ir_write0), .i_or_d(i_or_d0), .mem_write(mem_write0),
      .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .alu_src_a(alu_src_a0),
      .alu_src_b(alu_src_b0), .pc_src(pc_src0), .alu_op(alu_op0), .state(state0), .illegal(illegal0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit fn_known(logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   function automatic logic [2:0] fn_op(logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit op_known(logic [5:0] o);
      return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) || (o == 6'b000100) ||
             (o == 6'b001000) || (o == 6'b001111) || (o == 6'b000010);
   endfunction

   // Expected output vector for one cycle, straight from the per-state output list.
   function automatic logic [19:0] exp_out(state_t st, logic [5:0] opc, logic [5:0] fn, logic z, bit strict);
      logic pe, irw, iod, mw, rw, rd, mtr, asa, ill;
      logic [1:0] asb, pcs;
      logic [2:0] aop;
      {pe, irw, iod, mw, rw, rd, mtr, asa, ill} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 3'b000;
      case (st)
         S_FETCH:     begin irw = 1; pe = 1; asb = 2'b01; aop = 3'b010; end
         S_DECODE:    begin asb = 2'b11; aop = 3'b010; ill = strict && !op_known(opc); end
         S_MEM_ADDR:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
         S_MEM_READ:  iod = 1;
         S_MEM_WB:    begin rw = 1; mtr = 1; end
         S_MEM_WRITE: begin iod = 1; mw = 1; end
         S_R_EXEC:    begin asa = 1; aop = fn_op(fn); ill = strict && !fn_known(fn); end
         S_R_WB:      begin rd = 1; rw = fn_known(fn); end
         S_BRANCH:    begin asa = 1; aop = 3'b110; pcs = 2'b01; pe = z; end
         S_ADDI_EXEC: begin asa = 1; asb = 2'b10; aop = 3'b010; end
         S_LUI_EXEC:  begin asb = 2'b10; aop = 3'b011; end
         S_IMM_WB:    rw = 1;
         S_JUMP:      begin pe = 1; pcs = 2'b10; end
         default:     ;
      endcase
      return {4'(st), pe, irw, iod, mw, rw, rd, mtr, asa, asb, pcs, aop, ill};
   endfunction

   // Runs one instruction from FETCH through its last state. Opcode/funct/zero
   // carry random junk outside the cycles where they matter. If abort_at >= 0,
   // reset is raised during that step and the instruction is abandoned.
   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic zv, input int abort_at);
      logic [19:0] e1, e0, o1, o0;
      q_path = {};
      q_path.push_back(S_FETCH);
      q_path.push_back(S_DECODE);
      case (opc)
         6'b100011: begin q_path.push_back(S_MEM_ADDR); q_path.push_back(S_MEM_READ); q_path.push_back(S_MEM_WB); end
         6'b101011: begin q_path.push_back(S_MEM_ADDR); q_path.push_back(S_MEM_WRITE); end
         6'b000000: begin q_path.push_back(S_R_EXEC); q_path.push_back(S_R_WB); end
         6'b000100: q_path.push_back(S_BRANCH);
         6'b001000: begin q_path.push_back(S_ADDI_EXEC); q_path.push_back(S_IMM_WB); end
         6'b001111: begin q_path.push_back(S_LUI_EXEC); q_path.push_back(S_IMM_WB); end
         6'b000010: q_path.push_back(S_JUMP);
         default: ;
      endcase
      for (int i = 0; i < q_path.size(); i++) begin
         opcode = (q_path[i] == S_DECODE) ? opc : 6'($urandom);
         funct  = (q_path[i] == S_R_EXEC) ? fn  : 6'($urandom);
         zero   = (q_path[i] == S_BRANCH) ? zv  : 1'($urandom);
         if (i == abort_at) reset = 1'b1;
         #2;
         e1 = exp_out(q_path[i], opc, fn, zero, 1'b1);
         e0 = exp_out(q_path[i], opc, fn, zero, 1'b0);
         o1 = {state1, pc_en1, ir_write1, i_or_d1, mem_write1, reg_write1, reg_dst1, mem_to_reg1,
               alu_src_a1, alu_src_b1, pc_src1, alu_op1, illegal1};
         o0 = {state0, pc_en0, ir_write0, i_or_d0, mem_write0, reg_write0, reg_dst0, mem_to_reg0,
               alu_src_a0, alu_src_b0, pc_src0, alu_op0, illegal0};
         checks++;
         assert (o1 === e1) else begin
            errors++;
            $error("FAIL strict op=%b fn=%b step=%s observed=%h expected=%h", opc, fn, q_path[i].name(), o1, e1);
         end
         checks++;
         assert (o0 === e0) else begin
            errors++;
            $error("FAIL loose op=%b fn=%b step=%s observed=%h expected=%h", opc, fn, q_path[i].name(), o0, e0);
         end
         @(posedge clk);
         #1;
         if (i == abort_at) begin
            reset = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      logic [5:0] ops [7];
      logic [5:0] fns [5];
      logic [5:0] ro, rf;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001111, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      reset  = 1'b1;
      opcode = 6'd0;
      funct  = 6'd0;
      zero   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr(6'b100011, 6'd0, 1'b0, -1);        // lw
      run_instr(6'b101011, 6'd0, 1'b0, -1);        // sw
      for (int k = 0; k < 5; k++) run_instr(6'b000000, fns[k], 1'b0, -1);
      run_instr(6'b000000, 6'b111111, 1'b0, -1);   // unknown funct
      run_instr(6'b000100, 6'd0, 1'b1, -1);        // beq taken
      run_instr(6'b000100, 6'd0, 1'b0, -1);        // beq not taken
      run_instr(6'b001000, 6'd0, 1'b0, -1);        // addi
      run_instr(6'b001111, 6'd0, 1'b0, -1);        // lui
      run_instr(6'b000010, 6'd0, 1'b0, -1);        // j
      run_instr(6'b111111, 6'd0, 1'b0, -1);        // illegal opcode
      run_instr(6'b101011, 6'd0, 1'b0, 3);         // sw aborted in MEM_WRITE
      run_instr(6'b101011, 6'd0, 1'b0, -1);        // sw completes afterwards
      run_instr(6'b100011, 6'd0, 1'b0, 2);         // lw aborted in MEM_ADDR
      run_instr(6'b000000, 6'b101010, 1'b0, -1);

      for (int n = 0; n < 150; n++) begin
         ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         rf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(ro, rf, 1'($urandom), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
